// File: rtl/edge_bit_timer.sv
// edge_bit_timer: oversampling edge/bit timer for the UART RX datapath.
// Counts oversampling edges per bit (runtime prescale) and bits per frame
// (runtime frame length), and raises three mid-bit sample strobes plus
// bit-done / frame-done pulses.
// Optional build macro EDGE_BIT_TIMER_START_CHECK_EN adds rx_in/start_glitch
// to abort a frame whose start bit reads high at its centre sample.
module edge_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  sample_strobe,
    output logic [1:0]            sample_idx,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  busy
`ifdef EDGE_BIT_TIMER_START_CHECK_EN
    ,
    input  logic                  rx_in,
    output logic                  start_glitch
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_count_q, edge_count_d;
    logic [BIT_CNT_W-1:0]    bit_count_q, bit_count_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic [BIT_CNT_W-1:0]    frame_bits_q, frame_bits_d;
    logic                    busy_q, busy_d;

    logic [PRESCALE_W-1:0]   eff_pre, p_sel, mid, rel;
    logic [BIT_CNT_W-1:0]    eff_bits, n_sel;
    logic                    act, glitch;

    // Clamp the live config, pick live vs latched config, and decode strobes.
    // The strobe window test uses the edge offset from mid-1, so one unsigned
    // compare covers all three mid-bit edges.
    always_comb begin
        eff_pre  = (prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : prescale;
        eff_bits = (frame_bits == '0) ? BIT_CNT_W'(1) : frame_bits;
        p_sel    = (state_q == IDLE) ? eff_pre : prescale_q;
        n_sel    = (state_q == IDLE) ? eff_bits : frame_bits_q;
        mid      = p_sel >> 1;
        act      = enable & ~clear & ~rst;
        rel      = edge_count_q - (mid - PRESCALE_W'(1));

        sample_strobe = act & (rel < PRESCALE_W'(3));
        sample_idx    = sample_strobe ? rel[1:0] : 2'd0;
        bit_done      = act & (edge_count_q == p_sel - PRESCALE_W'(1));
        frame_done    = bit_done & (bit_count_q == n_sel - BIT_CNT_W'(1));
`ifdef EDGE_BIT_TIMER_START_CHECK_EN
        glitch        = sample_strobe & (state_q == COUNT) & (bit_count_q == '0) &
                        (rel == PRESCALE_W'(1)) & rx_in;
        start_glitch  = glitch;
`else
        glitch        = 1'b0;
`endif
    end

    // Next-state logic: clear first, then per-state counting and wrap.
    always_comb begin
        state_d      = state_q;
        edge_count_d = edge_count_q;
        bit_count_d  = bit_count_q;
        prescale_d   = prescale_q;
        frame_bits_d = frame_bits_q;

        if (clear) begin
            state_d      = IDLE;
            edge_count_d = '0;
            bit_count_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    edge_count_d = '0;
                    bit_count_d  = '0;
                    if (enable) begin
                        prescale_d   = eff_pre;
                        frame_bits_d = eff_bits;
                        edge_count_d = PRESCALE_W'(1);
                        state_d      = COUNT;
                    end
                end
                COUNT: begin
                    if (enable) begin
                        if (glitch || frame_done) begin
                            state_d      = IDLE;
                            edge_count_d = '0;
                            bit_count_d  = '0;
                        end else if (bit_done) begin
                            edge_count_d = '0;
                            bit_count_d  = bit_count_q + BIT_CNT_W'(1);
                        end else begin
                            edge_count_d = edge_count_q + PRESCALE_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == COUNT);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            edge_count_q <= '0;
            bit_count_q  <= '0;
            prescale_q   <= '0;
            frame_bits_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_count_q <= edge_count_d;
            bit_count_q  <= bit_count_d;
            prescale_q   <= prescale_d;
            frame_bits_q <= frame_bits_d;
            busy_q       <= busy_d;
        end
    end

    assign edge_count = edge_count_q;
    assign bit_count  = bit_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_edge_bit_timer.sv
// tb_edge_bit_timer: directed bench for edge_bit_timer.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit later, well clear of the next rising edge.
module tb_edge_bit_timer;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst, enable, clear;
    logic [PW-1:0] prescale;
    logic [BW-1:0] frame_bits;
    logic [PW-1:0] edge_count;
    logic [BW-1:0] bit_count;
    logic          sample_strobe, bit_done, frame_done, busy;
    logic [1:0]    sample_idx;
`ifdef EDGE_BIT_TIMER_START_CHECK_EN
    logic          rx_in, start_glitch;
`endif

    int checks = 0;
    int errors = 0;
    int fd_at;

    always #5 clk = ~clk;

    edge_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clear         (clear),
        .prescale      (prescale),
        .frame_bits    (frame_bits),
        .edge_count    (edge_count),
        .bit_count     (bit_count),
        .sample_strobe (sample_strobe),
        .sample_idx    (sample_idx),
        .bit_done      (bit_done),
        .frame_done    (frame_done),
        .busy          (busy)
`ifdef EDGE_BIT_TIMER_START_CHECK_EN
        ,
        .rx_in         (rx_in),
        .start_glitch  (start_glitch)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected outputs for cycle c (1 = start cycle) of an uninterrupted frame
    // with effective prescale p and nb bits, enable held high.
    task automatic frame_cyc(input string tag, input int c, input int p, input int nb);
        int e, b, m, s, idx, bd, fd, bz;
        e   = (c - 1) % p;
        b   = (c - 1) / p;
        m   = p / 2;
        s   = (e >= m - 1 && e <= m + 1) ? 1 : 0;
        idx = s ? e - (m - 1) : 0;
        bd  = (e == p - 1) ? 1 : 0;
        fd  = (bd && b == nb - 1) ? 1 : 0;
        bz  = (c > 1) ? 1 : 0;
        chk($sformatf("%s.c%0d.edge", tag, c), edge_count, e);
        chk($sformatf("%s.c%0d.bit", tag, c), bit_count, b);
        chk($sformatf("%s.c%0d.busy", tag, c), busy, bz);
        chk($sformatf("%s.c%0d.strobe", tag, c), sample_strobe, s);
        chk($sformatf("%s.c%0d.idx", tag, c), sample_idx, idx);
        chk($sformatf("%s.c%0d.bit_done", tag, c), bit_done, bd);
        chk($sformatf("%s.c%0d.frame_done", tag, c), frame_done, fd);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        prescale = PW'(8); frame_bits = BW'(10);
`ifdef EDGE_BIT_TIMER_START_CHECK_EN
        rx_in = 1'b0;
`endif
        tick(); tick();
        settle();
        chk("reset.edge", edge_count, 0);
        chk("reset.bit", bit_count, 0);
        chk("reset.busy", busy, 0);
        chk("reset.strobe", sample_strobe, 0);
        rst = 1'b0;
        tick();

        // Basic frame: prescale 8, 10 bits, frame_done on cycle 80.
        enable = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            settle();
            frame_cyc("basic", c, 8, 10);
            tick();
        end
        enable = 1'b0;
        settle();
        chk("basic.c81.busy", busy, 0);
        chk("basic.c81.edge", edge_count, 0);
        chk("basic.c81.bit", bit_count, 0);
        tick();

        // Reset mid-frame at edge 5 of bit 3.
        enable = 1'b1;
        for (int c = 1; c < 30; c++) tick();
        settle();
        chk("rstmid.edge", edge_count, 5);
        chk("rstmid.bit", bit_count, 3);
        rst = 1'b1;
        settle();
        chk("rstmid.strobe", sample_strobe, 0);
        chk("rstmid.idx", sample_idx, 0);
        chk("rstmid.bit_done", bit_done, 0);
        tick();
        rst = 1'b0; enable = 1'b0;
        settle();
        chk("rstmid.after.edge", edge_count, 0);
        chk("rstmid.after.bit", bit_count, 0);
        chk("rstmid.after.busy", busy, 0);
        tick();

        // Pause: prescale 16, 2 bits, enable low for cycles 7..11 at edge 6.
        prescale = PW'(16); frame_bits = BW'(2);
        fd_at = 0;
        for (int i = 1; i <= 100; i++) begin
            enable = !(i >= 7 && i <= 11);
            settle();
            if (i == 7)  chk("pause.c7.edge", edge_count, 6);
            if (i == 11) begin
                chk("pause.c11.edge", edge_count, 6);
                chk("pause.c11.busy", busy, 1);
                chk("pause.c11.bit_done", bit_done, 0);
                chk("pause.c11.strobe", sample_strobe, 0);
            end
            if (i == 12) chk("pause.c12.edge", edge_count, 6);
            if (frame_done === 1'b1) fd_at = i;
            tick();
            if (fd_at != 0) break;
        end
        enable = 1'b0;
        chk("pause.fd_cycle", fd_at, 37);
        settle();
        chk("pause.after.busy", busy, 0);
        tick();

        // Clamp: prescale 2 behaves as 4.
        prescale = PW'(2); frame_bits = BW'(2); enable = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            settle();
            frame_cyc("clamp", c, 4, 2);
            tick();
        end
        enable = 1'b0;
        settle();
        chk("clamp.after.busy", busy, 0);
        tick();

        // Config change mid-frame, then back-to-back frame with new prescale.
        prescale = PW'(16); frame_bits = BW'(6); enable = 1'b1;
        for (int c = 1; c <= 96; c++) begin
            if (c == 65) prescale = PW'(32);
            settle();
            frame_cyc("cfg", c, 16, 6);
            tick();
        end
        for (int d = 1; d <= 32; d++) begin
            settle();
            frame_cyc("b2b", d, 32, 6);
            tick();
        end
        clear = 1'b1;
        settle();
        chk("clrmid.strobe", sample_strobe, 0);
        chk("clrmid.bit", bit_count, 1);
        tick();
        clear = 1'b0; enable = 1'b0;
        settle();
        chk("clrmid.after.edge", edge_count, 0);
        chk("clrmid.after.bit", bit_count, 0);
        chk("clrmid.after.busy", busy, 0);
        tick();

        // Clear on the cycle frame_done would fire.
        prescale = PW'(4); frame_bits = BW'(2); enable = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            settle();
            frame_cyc("clrp", c, 4, 2);
            tick();
        end
        clear = 1'b1;
        settle();
        chk("clrp.c8.edge", edge_count, 3);
        chk("clrp.c8.bit", bit_count, 1);
        chk("clrp.c8.frame_done", frame_done, 0);
        chk("clrp.c8.bit_done", bit_done, 0);
        chk("clrp.c8.strobe", sample_strobe, 0);
        tick();
        clear = 1'b0;
        settle();
        chk("clrp.c9.edge", edge_count, 0);
        chk("clrp.c9.bit", bit_count, 0);
        chk("clrp.c9.busy", busy, 0);
        tick();
        settle();
        chk("clrp.c10.edge", edge_count, 1);
        chk("clrp.c10.busy", busy, 1);
        enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;

`ifdef EDGE_BIT_TIMER_START_CHECK_EN
        // Start-bit check: rx_in high at the bit-0 centre sample aborts.
        prescale = PW'(16); frame_bits = BW'(10); enable = 1'b1; rx_in = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            settle();
            chk($sformatf("glitch.c%0d.start_glitch", c), start_glitch, (c == 9) ? 1 : 0);
            chk($sformatf("glitch.c%0d.bit_done", c), bit_done, 0);
            tick();
        end
        enable = 1'b0; rx_in = 1'b0;
        settle();
        chk("glitch.after.edge", edge_count, 0);
        chk("glitch.after.busy", busy, 0);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            settle();
            frame_cyc("noglitch", c, 16, 10);
            chk($sformatf("noglitch.c%0d.start_glitch", c), start_glitch, 0);
            tick();
        end
        enable = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
